// File: rtl/div_param_pkg.sv
// Shared state encodings and level constants for the parametrised restoring divider.
package div_param_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract the divisor,
// keep the difference when it is non-negative and shift the outcome into the quotient.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] diff;
    logic           take;

    // rem < divisor always holds, so a set rem MSB means the shifted value exceeds the divisor
    assign diff      = {1'b0, rem[WIDTH-2:0], quot[WIDTH-1]} - {1'b0, divisor};
    assign take      = rem[WIDTH-1] | ~diff[WIDTH];
    assign rem_next  = take ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], quot[WIDTH-1]};
    assign quot_next = {quot[WIDTH-2:0], take};

endmodule

// File: rtl/div_param.sv
// Iterative restoring divider beside EX: FSM, step counter, sign fix-up and output registers.
// Result is {remainder, quotient}; EX holds start_i until it has consumed the result.
module div_param
    import div_param_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter bit ZERO_RESULT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH);

    div_state_e         state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   rem, quot, divisor;
    logic [WIDTH-1:0]   rem_next, quot_next;
    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;
    logic               neg_quot, neg_rem;
    logic               accept, dbz;
    logic [2*WIDTH-1:0] result;

    assign accept     = (state == DivFree) && (start_i == DivStart) && !annul_i;
    assign op1_abs    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign quot_fixed = neg_quot ? -quot : quot;
    assign rem_fixed  = neg_rem ? -rem : rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (accept) begin
                    state_next = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: state_next = annul_i ? DivFree : DivEnd;
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else if (cnt == CntLast) begin
                    state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_next = DivFree;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    // Magnitudes are divided unsigned; the latched sign flags restore signs on the final cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
            dbz      <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    if (accept) begin
                        rem      <= '0;
                        quot     <= op1_abs;
                        divisor  <= op2_abs;
                        cnt      <= '0;
                        neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
                        dbz      <= 1'b0;
                    end
                end
                DivByZero: begin
                    if (!annul_i) begin
                        result <= '0;
                        dbz    <= 1'b1;
                    end
                end
                DivOn: begin
                    if (!annul_i) begin
                        if (cnt != CntLast) begin
                            rem  <= rem_next;
                            quot <= quot_next;
                            cnt  <= cnt + 1'b1;
                        end else begin
                            result <= {rem_fixed, quot_fixed};
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        dbz <= 1'b0;
                        if (ZERO_RESULT) begin
                            result <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o       = (state == DivEnd) ? DivResultReady : DivResultNotReady;
    assign busy_o        = (state != DivFree);
    assign result_o      = result;
    assign div_by_zero_o = dbz;

endmodule
